// File: rtl/egress_arbiter_pkg.sv
// Shared types and helpers for the egress read arbiter and its priority selector.
//   arb_state_e : arbiter FSM state (idle / packet in progress)
//   MaxPorts    : largest supported number of FIFO read interfaces
//   PortIdxW    : port-index width covering MaxPorts
//   last_bit()  : bit position of the last-of-packet flag in a FIFO word
//   port_idx_w(): port-index width for a given port count
package egress_arbiter_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StPacket
    } arb_state_e;

    localparam int unsigned MaxPorts = 16;
    localparam int unsigned PortIdxW = $clog2(MaxPorts);

    function automatic int unsigned last_bit(input int unsigned data_width);
        return data_width - 1;
    endfunction

    function automatic int unsigned port_idx_w(input int unsigned num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/round_robin_priority_select.sv
// Combinational rotating-priority selector.
// Picks the first asserted request at or after pointer_i, wrapping at NUM_REQ.
//   req_i       : request vector, one bit per requester
//   pointer_i   : highest-priority index this cycle, must be < NUM_REQ
//   grant_idx_o : index of the selected requester (0 when none)
//   found_o     : at least one request is asserted
module round_robin_priority_select #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   pointer_i,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               found_o
);

    localparam logic [IDX_W:0] NumReqW = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W:0] cand;

    always_comb begin
        found_o     = 1'b0;
        grant_idx_o = '0;
        cand        = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            // Explicit wrap so non-power-of-two request counts rotate correctly.
            cand = {1'b0, pointer_i} + (IDX_W + 1)'(off);
            if (cand >= NumReqW) begin
                cand = cand - NumReqW;
            end
            if (!found_o && req_i[cand[IDX_W-1:0]]) begin
                found_o     = 1'b1;
                grant_idx_o = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_egress_read_arbiter.sv
// Packet-aware round-robin arbiter draining NUM_PORTS first-word-fall-through FIFO
// read sides into one egress stream. A grant is held until a word with the
// last-of-packet flag (MSB) is popped; a watchdog drops the grant if the granted
// FIFO runs dry mid-packet for STALL_TIMEOUT cycles.
//   clock, reset_n       : egress clock, synchronous active-low reset
//   fifo_read_data       : head word of each FIFO, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_read_data_valid : head word of port i is valid
//   fifo_read_enable     : pop strobe, one-hot or zero
//   out_data/out_last/out_valid/out_ready : one-deep registered egress stream
//   grant_port           : currently or last granted port
//   busy                 : packet in progress
//   stall_abort          : one-cycle pulse when the watchdog fires
module fifo_egress_read_arbiter
    import egress_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS     = 4,
    parameter int unsigned DATA_WIDTH    = 17,
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_read_data,
    input  logic [NUM_PORTS-1:0]            fifo_read_data_valid,
    output logic [NUM_PORTS-1:0]            fifo_read_enable,
    output logic [DATA_WIDTH-2:0]           out_data,
    output logic                            out_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_port,
    output logic                            busy,
    output logic                            stall_abort
);

    localparam int unsigned   IdxW     = port_idx_w(NUM_PORTS);
    localparam int unsigned   LastBit  = last_bit(DATA_WIDTH);
    localparam int unsigned   CntW     = $clog2(STALL_TIMEOUT) + 1;
    localparam logic [CntW-1:0] CntAbort = CntW'(STALL_TIMEOUT - 1);
    localparam logic [CntW-1:0] CntMax   = '1;
    localparam logic [IdxW-1:0] LastPort = IdxW'(NUM_PORTS - 1);

    arb_state_e            state_q, state_d;
    logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]       grant_q, grant_d;
    logic [CntW-1:0]       stall_cnt_q, stall_cnt_d;
    logic [DATA_WIDTH-2:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  stall_abort_q, stall_abort_d;

    logic                  can_load;
    logic                  sel_found;
    logic [IdxW-1:0]       sel_idx;
    logic [IdxW-1:0]       pop_idx;
    logic                  pop_req;
    logic                  pop_any;
    logic                  grant_valid;
    logic [DATA_WIDTH-1:0] pop_word;

    round_robin_priority_select #(
        .NUM_REQ (NUM_PORTS),
        .IDX_W   (IdxW)
    ) u_rr_select (
        .req_i       (fifo_read_data_valid),
        .pointer_i   (rr_ptr_q),
        .grant_idx_o (sel_idx),
        .found_o     (sel_found)
    );

    assign can_load    = !out_valid_q || out_ready;
    assign grant_valid = fifo_read_data_valid[grant_q];

    // In IDLE the candidate comes from the selector; in PACKET only the held grant.
    assign pop_idx = (state_q == StIdle) ? sel_idx : grant_q;
    assign pop_req = (state_q == StIdle) ? sel_found : grant_valid;
    // Pops are suppressed during reset so no FIFO word is lost while state clears.
    assign pop_any = reset_n && pop_req && can_load;

    always_comb begin
        fifo_read_enable = '0;
        if (pop_any) begin
            fifo_read_enable[pop_idx] = 1'b1;
        end
    end

    always_comb begin
        pop_word = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (IdxW'(i) == pop_idx) begin
                pop_word = fifo_read_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        stall_cnt_d   = stall_cnt_q;
        stall_abort_d = 1'b0;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        out_valid_d   = out_valid_q;

        unique case (state_q)
            StIdle: begin
                stall_cnt_d = '0;
                if (pop_any) begin
                    grant_d  = sel_idx;
                    rr_ptr_d = (sel_idx == LastPort) ? '0 : sel_idx + 1'b1;
                end
            end
            StPacket: begin
                if (grant_valid) begin
                    // Backpressure alone is not a stall: counter only clears on a pop.
                    if (pop_any) begin
                        stall_cnt_d = '0;
                    end
                end else if (stall_cnt_q == CntAbort) begin
                    stall_abort_d = 1'b1;
                    stall_cnt_d   = '0;
                    state_d       = StIdle;
                end else if (stall_cnt_q != CntMax) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop_any) begin
            out_data_d  = pop_word[DATA_WIDTH-2:0];
            out_last_d  = pop_word[LastBit];
            out_valid_d = 1'b1;
            state_d     = pop_word[LastBit] ? StIdle : StPacket;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Stays high through the cycle after the final pop of a packet.
        busy_d = pop_any || (state_d == StPacket);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            stall_cnt_q   <= '0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            stall_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            stall_cnt_q   <= stall_cnt_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            stall_abort_q <= stall_abort_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign out_valid   = out_valid_q;
    assign grant_port  = grant_q;
    assign busy        = busy_q;
    assign stall_abort = stall_abort_q;

endmodule

// File: tb/tb_fifo_egress_read_arbiter.sv
// Self-checking bench for fifo_egress_read_arbiter: per-port FIFO queues feed the
// DUT, expected egress words are queued at load time and compared on acceptance.
module tb_fifo_egress_read_arbiter;

    localparam int NP = 4;
    localparam int DW = 17;
    localparam int ST = 8;
    localparam int IW = 2;
    localparam int NP3 = 3;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [NP*DW-1:0]  fifo_read_data = '0;
    logic [NP-1:0]     fifo_read_data_valid = '0;
    logic [NP-1:0]     fifo_read_enable;
    logic [DW-2:0]     out_data;
    logic              out_last;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [IW-1:0]     grant_port;
    logic              busy;
    logic              stall_abort;

    logic [NP3*DW-1:0] d3_data = '0;
    logic [NP3-1:0]    d3_valid = '0;
    logic [NP3-1:0]    d3_en;
    logic [DW-2:0]     d3_out_data;
    logic              d3_out_last;
    logic              d3_out_valid;
    logic [1:0]        d3_grant;
    logic              d3_busy;
    logic              d3_abort;

    always #5 clock = ~clock;

    fifo_egress_read_arbiter #(
        .NUM_PORTS     (NP),
        .DATA_WIDTH    (DW),
        .STALL_TIMEOUT (ST)
    ) u_dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .fifo_read_data       (fifo_read_data),
        .fifo_read_data_valid (fifo_read_data_valid),
        .fifo_read_enable     (fifo_read_enable),
        .out_data             (out_data),
        .out_last             (out_last),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .grant_port           (grant_port),
        .busy                 (busy),
        .stall_abort          (stall_abort)
    );

    fifo_egress_read_arbiter #(
        .NUM_PORTS     (NP3),
        .DATA_WIDTH    (DW),
        .STALL_TIMEOUT (ST)
    ) u_dut3 (
        .clock                (clock),
        .reset_n              (reset_n),
        .fifo_read_data       (d3_data),
        .fifo_read_data_valid (d3_valid),
        .fifo_read_enable     (d3_en),
        .out_data             (d3_out_data),
        .out_last             (d3_out_last),
        .out_valid            (d3_out_valid),
        .out_ready            (1'b1),
        .grant_port           (d3_grant),
        .busy                 (d3_busy),
        .stall_abort          (d3_abort)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [DW-1:0] fq[NP][$];
    logic [31:0]   exp_q[$];

    // Values sampled at the most recent falling edge.
    int            s_cyc;
    logic [NP-1:0] s_en;
    logic          s_valid, s_last, s_busy, s_abort;
    logic [DW-2:0] s_data;
    logic [IW-1:0] s_grant;

    logic          p_hold = 1'b0;
    logic [DW-2:0] p_data;
    logic          p_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_word(input int port, input logic last,
                                              input logic [15:0] pay);
        return (32'(port) << 17) | (32'(last) << 16) | 32'(pay);
    endfunction

    task automatic drive_fifos();
        for (int i = 0; i < NP; i++) begin
            if (fq[i].size() > 0) begin
                fifo_read_data_valid[i]    = 1'b1;
                fifo_read_data[i*DW +: DW] = fq[i][0];
            end else begin
                fifo_read_data_valid[i]    = 1'b0;
                fifo_read_data[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic add_pkt(input int port, input int n, input int base);
        for (int k = 0; k < n; k++) begin
            logic last;
            last = (k == n - 1);
            fq[port].push_back({last, 16'(base + k)});
            exp_q.push_back(pack_word(port, last, 16'(base + k)));
        end
        drive_fifos();
    endtask

    task automatic tick();
        logic [31:0] e;
        @(negedge clock);
        s_cyc   = cyc;
        s_en    = fifo_read_enable;
        s_valid = out_valid;
        s_data  = out_data;
        s_last  = out_last;
        s_grant = grant_port;
        s_busy  = busy;
        s_abort = stall_abort;
        if (s_en != '0) begin
            check_eq("pop_onehot", 32'($onehot(s_en)), 32'd1);
            check_eq("pop_needs_valid", 32'(s_en & ~fifo_read_data_valid), 32'd0);
        end
        if (p_hold) begin
            check_eq("hold_valid", 32'(s_valid), 32'd1);
            check_eq("hold_data", 32'(s_data), 32'(p_data));
            check_eq("hold_last", 32'(s_last), 32'(p_last));
        end
        if (s_valid === 1'b1 && out_ready === 1'b0) begin
            check_eq("hold_no_pop", 32'(s_en), 32'd0);
        end
        if (s_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underrun", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_word", 32'({s_grant, s_last, s_data}), e);
            end
        end
        p_hold = (s_valid === 1'b1) && (out_ready === 1'b0) && (reset_n === 1'b1);
        p_data = s_data;
        p_last = s_last;
        @(posedge clock);
        cyc++;
        #1;
        for (int i = 0; i < NP; i++) begin
            if (s_en[i] === 1'b1 && fq[i].size() > 0) begin
                void'(fq[i].pop_front());
            end
        end
        drive_fifos();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NP; i++) fq[i].delete();
        exp_q.delete();
        drive_fifos();
        tick();
        tick();
        reset_n = 1'b1;
        p_hold  = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) tick();
        check_eq(tag, 32'(exp_q.size()), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pop_cyc;
        int abort_cyc;
        int abort_cnt;
        int idx;

        // Reset values
        do_reset();
        check_eq("rst_out_valid", 32'(s_valid), 32'd0);
        check_eq("rst_out_data", 32'(s_data), 32'd0);
        check_eq("rst_out_last", 32'(s_last), 32'd0);
        check_eq("rst_grant", 32'(s_grant), 32'd0);
        check_eq("rst_busy", 32'(s_busy), 32'd0);
        check_eq("rst_abort", 32'(s_abort), 32'd0);
        check_eq("rst_enable", 32'(s_en), 32'd0);

        // Single 3-word packet on port 2
        do_reset();
        add_pkt(2, 3, 'hA1);
        tick();
        check_eq("t1_first_pop", 32'(s_en), 32'h4);
        check_eq("t1_latency", 32'(s_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t1_consec", 32'(s_valid), 32'd1);
            check_eq("t1_busy", 32'(s_busy), 32'd1);
        end
        check_eq("t1_last", 32'(s_last), 32'd1);
        tick();
        check_eq("t1_busy_fall", 32'(s_busy), 32'd0);
        check_eq("t1_idle_valid", 32'(s_valid), 32'd0);
        drain("t1_drain");

        // Round robin across ports 0, 1, 3 with two packets each
        do_reset();
        add_pkt(0, 2, 'h10);
        add_pkt(1, 2, 'h20);
        add_pkt(3, 2, 'h30);
        add_pkt(0, 2, 'h40);
        add_pkt(1, 2, 'h50);
        add_pkt(3, 2, 'h60);
        drain("t2_drain");

        // Backpressure during a 4-word packet
        do_reset();
        add_pkt(0, 4, 'h70);
        for (int k = 0; k < 12; k++) begin
            out_ready = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            tick();
        end
        out_ready = 1'b1;
        drain("t3_drain");

        // Stall watchdog on port 1, port 2 pending
        do_reset();
        fq[1].push_back({1'b0, 16'hB1});
        exp_q.push_back(pack_word(1, 1'b0, 16'hB1));
        add_pkt(2, 2, 'hC0);
        pop_cyc   = -100;
        abort_cyc = -1;
        abort_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (s_en[1] === 1'b1) pop_cyc = s_cyc;
            if (s_abort === 1'b1) begin
                abort_cnt++;
                abort_cyc = s_cyc;
                check_eq("t4_busy_at_abort", 32'(s_busy), 32'd0);
            end
        end
        check_eq("t4_abort_pulses", 32'(abort_cnt), 32'd1);
        check_eq("t4_abort_cycle", 32'(abort_cyc), 32'(pop_cyc + 9));
        drain("t4_drain");

        // Reset mid-packet on port 0
        do_reset();
        for (int k = 0; k < 4; k++) fq[0].push_back({k == 3, 16'(16'hD0 + k)});
        fq[1].push_back({1'b1, 16'hE0});
        exp_q.push_back(pack_word(0, 1'b0, 16'hD0));
        exp_q.push_back(pack_word(0, 1'b0, 16'hD2));
        exp_q.push_back(pack_word(0, 1'b1, 16'hD3));
        exp_q.push_back(pack_word(1, 1'b1, 16'hE0));
        drive_fifos();
        for (int k = 0; k < 10 && fq[0].size() != 2; k++) tick();
        check_eq("t5_reached_mid", 32'(fq[0].size()), 32'd2);
        reset_n   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check_eq("t5_out_valid", 32'(s_valid), 32'd0);
        check_eq("t5_out_data", 32'(s_data), 32'd0);
        check_eq("t5_out_last", 32'(s_last), 32'd0);
        check_eq("t5_grant", 32'(s_grant), 32'd0);
        check_eq("t5_busy", 32'(s_busy), 32'd0);
        check_eq("t5_enable", 32'(s_en), 32'd0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        p_hold    = 1'b0;
        drain("t5_drain");

        // Three-port instance, all ports continuously offering single-word packets
        do_reset();
        for (int i = 0; i < NP3; i++) d3_data[i*DW +: DW] = {1'b1, 16'(i)};
        d3_valid = '1;
        idx = 0;
        for (int k = 0; k < 30 && idx < 7; k++) begin
            @(negedge clock);
            if (d3_en != '0) check_eq("t6_pop_onehot", 32'($onehot(d3_en)), 32'd1);
            if (d3_out_valid === 1'b1) begin
                check_eq("t6_grant", 32'(d3_grant), 32'(idx % 3));
                check_eq("t6_data", 32'(d3_out_data), 32'(idx % 3));
                check_eq("t6_last", 32'(d3_out_last), 32'd1);
                idx++;
            end
        end
        check_eq("t6_count", 32'(idx), 32'd7);
        d3_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
